// File: rtl/vehicle_sensor_conditioner_if.sv
// Loop-detector conditioner signal bundle.
// Sensor inputs toward the conditioner, request/status outputs back.
interface vehicle_sensor_conditioner_if;
  logic       sensor_raw;
  logic       green_ack;
  logic       car_detect;
  logic [7:0] car_count;
  logic       fault;

  modport master (
    output sensor_raw,
    output green_ack,
    input  car_detect,
    input  car_count,
    input  fault
  );

  modport slave (
    input  sensor_raw,
    input  green_ack,
    output car_detect,
    output car_count,
    output fault
  );
endinterface

// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector conditioner: sync, debounce, hold and stuck detection.
// Feeds a traffic light controller with a clean car_detect request.
module vehicle_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 32
) (
  input logic                         clk,
  input logic                         reset,
  vehicle_sensor_conditioner_if.slave sns
);

  typedef enum logic [1:0] {
    IDLE,
    DETECT,
    HOLD,
    FAULT
  } state_t;

  localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LOAD  = 8'(HOLD_CYCLES);
  localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);

  logic        s_meta;
  logic        s_sync;
  logic        sensor_db;
  logic [7:0]  db_cnt;
  logic [7:0]  hold_cnt;
  logic [15:0] stuck_cnt;
  state_t      state;
  logic        car_detect_q;
  logic [7:0]  car_count_q;
  logic        fault_q;
  logic [7:0]  count_inc;

  assign count_inc = (car_count_q == 8'hff) ? car_count_q
                                            : car_count_q + 8'd1;

  assign sns.car_detect = car_detect_q;
  assign sns.car_count  = car_count_q;
  assign sns.fault      = fault_q;

  // Two-flop synchronizer for the asynchronous loop level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      s_meta <= sns.sensor_raw;
      s_sync <= s_meta;
    end
  end

  // Debounce: flip only after a full run of differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sensor_db <= 1'b0;
      db_cnt    <= 8'd0;
    end else if (s_sync == sensor_db) begin
      db_cnt <= 8'd0;
    end else if (db_cnt == DB_LAST) begin
      sensor_db <= s_sync;
      db_cnt    <= 8'd0;
    end else begin
      db_cnt <= db_cnt + 8'd1;
    end
  end

  // Presence FSM with registered request, count and sticky fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      car_detect_q <= 1'b0;
      car_count_q  <= 8'd0;
      fault_q      <= 1'b0;
      hold_cnt     <= 8'd0;
      stuck_cnt    <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sensor_db) begin
            state        <= DETECT;
            car_detect_q <= 1'b1;
            car_count_q  <= count_inc;
            stuck_cnt    <= 16'd0;
          end
        end
        DETECT: begin
          if (!sensor_db) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end else if (stuck_cnt == STUCK_LAST) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end else begin
            stuck_cnt <= stuck_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (sensor_db) begin
            state       <= DETECT;
            car_count_q <= count_inc;
            stuck_cnt   <= 16'd0;
          end else if (sns.green_ack || hold_cnt == 8'd1) begin
            state        <= IDLE;
            car_detect_q <= 1'b0;
            hold_cnt     <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        FAULT: begin
          if (!sensor_db) begin
            state        <= IDLE;
            car_detect_q <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          car_detect_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Bench for vehicle_sensor_conditioner.
// Random and directed stimulus against a cycle reference model.
module tb_vehicle_sensor_conditioner;

  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  vehicle_sensor_conditioner_if sns();

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sns(sns)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];

  bit m_s1, m_s2, m_db;
  int m_run;
  bit m_present, m_faulted, m_fault;
  int m_hold_left, m_dwell, m_count;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold_raw(input bit v, input int n);
    sns.sensor_raw = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: one expected output word per rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
      m_present = 0; m_faulted = 0; m_fault = 0;
      m_hold_left = 0; m_dwell = 0; m_count = 0;
      exp_q.delete();
    end else begin
      bit db_now;
      bit det;
      db_now = m_db;
      if (m_faulted) begin
        if (!db_now) m_faulted = 0;
      end else if (m_present) begin
        if (!db_now) begin
          m_present = 0;
          m_hold_left = HOLD;
        end else begin
          m_dwell++;
          if (m_dwell == STUCK) begin
            m_present = 0;
            m_faulted = 1;
            m_fault = 1;
          end
        end
      end else if (db_now) begin
        m_present = 1;
        m_hold_left = 0;
        m_dwell = 0;
        if (m_count < 255) m_count++;
      end else if (m_hold_left > 0) begin
        if (sns.green_ack) m_hold_left = 0;
        else m_hold_left--;
      end
      if (m_s2 == m_db) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == DEB) begin
          m_db = m_s2;
          m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sns.sensor_raw;
      det = m_present || m_faulted || (m_hold_left > 0);
      exp_q.push_back({det, 8'(m_count), m_fault});
    end
  end

  // Monitor: compare DUT outputs with the next expected word.
  always @(negedge clk) begin
    if (reset) begin
      logic [9:0] a;
      logic [9:0] e;
      a = {sns.car_detect, sns.car_count, sns.fault};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got %h expected an entry", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got det=%b cnt=%0d flt=%b expected det=%b cnt=%0d flt=%b",
                   $time, a[9], a[8:1], a[0], e[9], e[8:1], e[0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    sns.sensor_raw = 1'b0;
    sns.green_ack = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_detect", int'(sns.car_detect), 0);
    check("reset_count", int'(sns.car_count), 0);
    check("reset_fault", int'(sns.fault), 0);
    #1 reset = 1'b1;
    @(negedge clk);

    hold_raw(1, 3);
    hold_raw(0, 15);
    check("glitch_detect", int'(sns.car_detect), 0);
    check("glitch_count", int'(sns.car_count), 0);

    sns.sensor_raw = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (sns.car_detect) begin
        lat = k;
        break;
      end
    end
    check("latency_edges", lat, DEB + 3);
    @(negedge clk);
    hold_raw(1, 12);
    hold_raw(0, 25);
    check("clean_count", int'(sns.car_count), 1);
    check("clean_released", int'(sns.car_detect), 0);

    hold_raw(1, 10);
    hold_raw(0, 8);
    check("in_hold_detect", int'(sns.car_detect), 1);
    sns.green_ack = 1'b1;
    @(posedge clk);
    #1;
    check("early_serve", int'(sns.car_detect), 0);
    @(negedge clk);
    sns.green_ack = 1'b0;
    hold_raw(0, 10);

    for (int off = 0; off < 12; off++) begin
      hold_raw(1, 10);
      hold_raw(0, 6);
      sns.sensor_raw = 1'b1;
      for (int i = 0; i < 12; i++) begin
        sns.green_ack = (i == off);
        @(negedge clk);
      end
      sns.green_ack = 1'b0;
      hold_raw(0, 20);
    end

    hold_raw(1, 40);
    check("stuck_fault", int'(sns.fault), 1);
    check("stuck_detect", int'(sns.car_detect), 1);
    hold_raw(0, 10);
    check("stuck_release", int'(sns.car_detect), 0);
    check("stuck_sticky", int'(sns.fault), 1);

    repeat (150) begin
      int len;
      len = $urandom_range(1, 30);
      sns.sensor_raw = 1'($urandom_range(0, 1));
      repeat (len) begin
        sns.green_ack = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
    end
    sns.green_ack = 1'b0;
    hold_raw(0, 20);

    #2 reset = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    repeat (257) begin
      hold_raw(1, 6);
      hold_raw(0, 6);
    end
    hold_raw(0, 20);
    check("sat_count", int'(sns.car_count), 255);
    check("sat_idle", int'(sns.car_detect), 0);

    hold_raw(1, 10);
    hold_raw(0, 9);
    check("pre_reset_detect", int'(sns.car_detect), 1);
    #2 reset = 1'b0;
    #1;
    check("async_detect", int'(sns.car_detect), 0);
    check("async_count", int'(sns.car_count), 0);
    check("async_fault", int'(sns.fault), 0);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_detect", int'(sns.car_detect), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
